// File: rtl/ct_field_unconv.sv
// Reverse field converter: maps an output-domain field back to its input-domain value
// through the IF/OF table, with a 2-entry registered skid buffer on the output.
// Optional macro CT_FIELD_UNCONV_PASSTHRU_UNMATCHED_EN forwards unmatched beats with o_field = 0.
module ct_field_unconv #(
    parameter int unsigned WD        = 8,
    parameter int unsigned WIF       = 2,
    parameter int unsigned WOF       = 4,
    parameter int unsigned N_ENTRIES = 3,
    parameter logic [N_ENTRIES*WIF-1:0] IF = 6'b10_01_00,
    parameter logic [N_ENTRIES*WOF-1:0] OF = 12'hC53,
    parameter int unsigned WERR      = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [WD-1:0]   i_data,
    input  logic [WOF-1:0]  i_field,
    input  logic            i_valid,
    output logic            o_ready,
    output logic [WD-1:0]   o_data,
    output logic [WIF-1:0]  o_field,
    output logic            o_valid,
    input  logic            i_ready,
    output logic            o_err,
    output logic [WERR-1:0] o_err_count
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t         state, next_state;
    logic           hit_c;
    logic [WIF-1:0] lut_field_c;
    logic           accept_c;
    logic           beat_c;
    logic           take_c;
    logic           unmatched_c;
    logic           ld_m_in_c;
    logic           ld_m_skid_c;
    logic           ld_s_c;
    logic [WD-1:0]  skid_data;
    logic [WIF-1:0] skid_field;

    // Table lookup; the lowest matching index wins, no match leaves the field at zero.
    always_comb begin
        hit_c       = 1'b0;
        lut_field_c = '0;
        for (int unsigned i = 0; i < N_ENTRIES; i++) begin
            if (!hit_c && (OF[WOF*i +: WOF] == i_field)) begin
                hit_c       = 1'b1;
                lut_field_c = IF[WIF*i +: WIF];
            end
        end
    end

    assign accept_c    = i_valid & o_ready;
    assign take_c      = o_valid & i_ready;
    assign unmatched_c = accept_c & ~hit_c;
`ifdef CT_FIELD_UNCONV_PASSTHRU_UNMATCHED_EN
    assign beat_c      = accept_c;
`else
    assign beat_c      = accept_c & hit_c;
`endif

    // Skid FSM: decides where an incoming beat lands and when the skid drains into main.
    always_comb begin
        next_state  = state;
        ld_m_in_c   = 1'b0;
        ld_m_skid_c = 1'b0;
        ld_s_c      = 1'b0;
        case (state)
            EMPTY: begin
                if (beat_c) begin
                    ld_m_in_c  = 1'b1;
                    next_state = ONE;
                end
            end
            ONE: begin
                if (beat_c && take_c) begin
                    ld_m_in_c = 1'b1;
                end else if (beat_c) begin
                    ld_s_c     = 1'b1;
                    next_state = FULL;
                end else if (take_c) begin
                    next_state = EMPTY;
                end
            end
            FULL: begin
                if (take_c) begin
                    ld_m_skid_c = 1'b1;
                    next_state  = ONE;
                end
            end
            default: next_state = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= EMPTY;
            o_valid <= 1'b0;
            o_ready <= 1'b0;
        end else begin
            state   <= next_state;
            o_valid <= (next_state != EMPTY);
            o_ready <= (next_state != FULL);
        end
    end

    // Error pulse and saturating unmatched-beat counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_err       <= 1'b0;
            o_err_count <= '0;
        end else begin
            o_err <= unmatched_c;
            if (unmatched_c && (o_err_count != {WERR{1'b1}})) begin
                o_err_count <= o_err_count + WERR'(1);
            end
        end
    end

    // Payload registers carry no reset; their contents are only meaningful while o_valid is high.
    always_ff @(posedge clk) begin
        if (ld_m_in_c) begin
            o_data  <= i_data;
            o_field <= lut_field_c;
        end else if (ld_m_skid_c) begin
            o_data  <= skid_data;
            o_field <= skid_field;
        end
        if (ld_s_c) begin
            skid_data  <= i_data;
            skid_field <= lut_field_c;
        end
    end

endmodule

// File: tb/tb_ct_field_unconv.sv
// Bench for ct_field_unconv: vector table, hand-written corner sequences and a random
// stream checked against a queue-based reference model.
module tb_ct_field_unconv;

    localparam int unsigned WD   = 8;
    localparam int unsigned WIF  = 2;
    localparam int unsigned WOF  = 4;
    localparam int unsigned N    = 4;
    localparam int unsigned WERR = 2;
    localparam int          CMAX = 3;
    // Entry 3 duplicates entry 1's OF value so the lowest-index rule is exercised.
    localparam logic [N*WIF-1:0] IF_V = {2'd3, 2'd2, 2'd1, 2'd0};
    localparam logic [N*WOF-1:0] OF_V = {4'h5, 4'hC, 4'h5, 4'h3};
`ifdef CT_FIELD_UNCONV_PASSTHRU_UNMATCHED_EN
    localparam bit PASS = 1'b1;
`else
    localparam bit PASS = 1'b0;
`endif

    logic            clk;
    logic            reset;
    logic [WD-1:0]   i_data;
    logic [WOF-1:0]  i_field;
    logic            i_valid;
    logic            o_ready;
    logic [WD-1:0]   o_data;
    logic [WIF-1:0]  o_field;
    logic            o_valid;
    logic            i_ready;
    logic            o_err;
    logic [WERR-1:0] o_err_count;

    ct_field_unconv #(
        .WD(WD), .WIF(WIF), .WOF(WOF), .N_ENTRIES(N),
        .IF(IF_V), .OF(OF_V), .WERR(WERR)
    ) dut (
        .clk(clk), .reset(reset),
        .i_data(i_data), .i_field(i_field), .i_valid(i_valid), .o_ready(o_ready),
        .o_data(o_data), .o_field(o_field), .o_valid(o_valid), .i_ready(i_ready),
        .o_err(o_err), .o_err_count(o_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [3:0] fld;
    } beat_t;

    typedef struct {
        logic [3:0] fld;
        logic [7:0] data;
        bit         exp_valid;
        logic [1:0] exp_field;
        bit         exp_err;
    } vec_t;

    int of_t[N] = '{3, 5, 12, 5};
    int if_t[N] = '{0, 1, 2, 3};
    int pick_t[3] = '{3, 5, 12};

    beat_t src[$];
    beat_t mq[$];
    beat_t out_log[$];
    bit    m_ready, m_err, pending;
    int    m_cnt;
    int    takes, err_pulses, ready_low;
    int    errors, checks;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void lookup(input int f, output bit hit, output int val);
        hit = 1'b0;
        val = 0;
        for (int i = 0; i < N; i++) begin
            if (!hit && of_t[i] == f) begin
                hit = 1'b1;
                val = if_t[i];
            end
        end
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ready = 1'b0;
        m_err   = 1'b0;
        m_cnt   = 0;
        pending = 1'b0;
    endtask

    // Reference: FIFO of at most two beats; ready means the FIFO was not full after the edge.
    task automatic model_update();
        bit    acc, hit;
        int    v;
        beat_t b;
        if (!reset) begin
            model_reset();
        end else begin
            acc = i_valid && m_ready;
            if (mq.size() > 0 && i_ready) begin
                out_log.push_back(mq.pop_front());
                takes++;
            end
            m_err = 1'b0;
            if (acc) begin
                lookup(int'(i_field), hit, v);
                b.data = i_data;
                b.fld  = 4'(v);
                if (hit || PASS) mq.push_back(b);
                if (!hit) begin
                    m_err = 1'b1;
                    if (m_cnt < CMAX) m_cnt++;
                end
                if (src.size() > 0) void'(src.pop_front());
            end
            pending = i_valid && !acc;
            m_ready = (mq.size() != 2);
        end
    endtask

    task automatic check_model();
        chk("o_valid", int'(o_valid), int'(mq.size() > 0));
        chk("o_ready", int'(o_ready), int'(m_ready));
        chk("o_err", int'(o_err), int'(m_err));
        chk("o_err_count", int'(o_err_count), m_cnt);
        if (mq.size() > 0) begin
            chk("o_data", int'(o_data), int'(mq[0].data));
            chk("o_field", int'(o_field), int'(mq[0].fld));
        end
    endtask

    // One clock: drive at the falling edge, compare, then advance the model on the rising edge.
    task automatic tick(input bit rdy, input bit gap = 1'b0);
        i_ready = rdy;
        if (src.size() > 0 && (pending || !gap)) begin
            i_valid = 1'b1;
            i_field = src[0].fld;
            i_data  = src[0].data;
        end else begin
            i_valid = 1'b0;
        end
        check_model();
        if (o_err) err_pulses++;
        if (!o_ready) ready_low++;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        i_valid = 1'b0;
        src.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick(1'b1);
    endtask

    function automatic beat_t rand_beat();
        beat_t b;
        int    r;
        r = int'($urandom_range(0, 3));
        b.data = 8'($urandom_range(0, 255));
        b.fld  = (r == 3) ? 4'($urandom_range(0, 15)) : 4'(pick_t[r]);
        return b;
    endfunction

    vec_t vt[6];

    initial begin
        int e0, t0;
        errors = 0; checks = 0; takes = 0; err_pulses = 0; ready_low = 0;
        reset = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_data = '0; i_field = '0;

        vt[0] = '{4'h5, 8'hAA, 1'b1, 2'd1, 1'b0};
        vt[1] = '{4'h3, 8'h11, 1'b1, 2'd0, 1'b0};
        vt[2] = '{4'hC, 8'h5C, 1'b1, 2'd2, 1'b0};
        vt[3] = '{4'h7, 8'h77, PASS, 2'd0, 1'b1};
        vt[4] = '{4'h0, 8'h00, PASS, 2'd0, 1'b1};
        vt[5] = '{4'hF, 8'hFF, PASS, 2'd0, 1'b1};

        // Reset state and first ready edge
        model_reset();
        repeat (2) @(negedge clk);
        check_model();
        reset = 1'b1;
        tick(1'b1);
        chk("ready_after_reset", int'(o_ready), 1);

        // Vector table: single beats, output inspected one cycle after acceptance
        for (int i = 0; i < 6; i++) begin
            src.push_back('{vt[i].data, vt[i].fld});
            tick(1'b1);
            chk("vec_valid", int'(o_valid), int'(vt[i].exp_valid));
            if (vt[i].exp_valid) begin
                chk("vec_field", int'(o_field), int'(vt[i].exp_field));
                chk("vec_data", int'(o_data), int'(vt[i].data));
            end
            chk("vec_err", int'(o_err), int'(vt[i].exp_err));
            tick(1'b1);
        end

        // Backpressure: three beats into a stalled sink
        do_reset();
        src.push_back('{8'h01, 4'h3});
        src.push_back('{8'h02, 4'h5});
        src.push_back('{8'h03, 4'hC});
        tick(1'b0);
        tick(1'b0);
        chk("bp_ready_low", int'(o_ready), 0);
        tick(1'b0);
        tick(1'b0);
        chk("bp_hold_field", int'(o_field), 0);
        chk("bp_hold_data", int'(o_data), 1);
        out_log.delete();
        repeat (5) tick(1'b1);
        chk("bp_out_count", out_log.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (k < out_log.size()) chk("bp_order", int'(out_log[k].fld), k);
        end

        // Throughput: 100 matched beats in 101 cycles
        do_reset();
        t0 = takes;
        ready_low = 0;
        for (int k = 0; k < 100; k++) begin
            beat_t b;
            b.data = 8'(k);
            b.fld  = 4'(pick_t[k % 3]);
            src.push_back(b);
        end
        repeat (101) tick(1'b1);
        chk("tp_beats", takes - t0, 100);
        chk("tp_ready_low", ready_low, 0);
        chk("tp_src_left", src.size(), 0);

        // Single unmatched beat
        do_reset();
        e0 = err_pulses;
        t0 = takes;
        src.push_back('{8'h77, 4'h7});
        repeat (3) tick(1'b1);
        chk("um_pulses", err_pulses - e0, 1);
        chk("um_count", int'(o_err_count), 1);
        chk("um_beats", takes - t0, int'(PASS));

        // Counter saturation
        do_reset();
        e0 = err_pulses;
        src.push_back('{8'h10, 4'h7});
        src.push_back('{8'h11, 4'h0});
        src.push_back('{8'h12, 4'hF});
        src.push_back('{8'h13, 4'h9});
        src.push_back('{8'h14, 4'h1});
        repeat (8) tick(1'b1);
        chk("sat_pulses", err_pulses - e0, 5);
        chk("sat_count", int'(o_err_count), CMAX);

        // Reset while FULL
        do_reset();
        src.push_back('{8'h70, 4'h7});
        tick(1'b1);
        tick(1'b1);
        src.push_back('{8'h31, 4'h3});
        src.push_back('{8'h32, 4'h5});
        tick(1'b0);
        tick(1'b0);
        chk("mr_full_ready", int'(o_ready), 0);
        chk("mr_full_valid", int'(o_valid), 1);
        chk("mr_count_before", int'(o_err_count), 1);
        #2 reset = 1'b0;
        #1;
        chk("mr_valid_async", int'(o_valid), 0);
        chk("mr_count_async", int'(o_err_count), 0);
        model_reset();
        src.delete();
        i_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        t0 = takes;
        chk("mr_ready_first", int'(o_ready), 0);
        tick(1'b1);
        chk("mr_ready_then", int'(o_ready), 1);
        repeat (3) tick(1'b1);
        chk("mr_no_stale", takes - t0, 0);

        // Random stream against the model
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if (src.size() < 3 && $urandom_range(0, 3) != 0) src.push_back(rand_beat());
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0);
        end
        repeat (10) tick(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
